// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the pipeline stage register: skid buffer state encoding
// and a helper that maps a state to its occupancy.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    function automatic logic [1:0] skid_count(input skid_state_e s);
        logic [1:0] c;
        case (s)
            SKID_ONE: c = 2'd1;
            SKID_TWO: c = 2'd2;
            default:  c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready/payload handshake bundle between two pipeline stages.
// The master drives valid and data; the slave drives ready.
interface pipe_skid_reg_if #(
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and
// an optional two-entry skid buffer that registers the backward ready path.
//
//   state      | meaning
//   SKID_EMPTY | nothing held, ready_o high
//   SKID_ONE   | main register holds the head entry, ready_o high
//   SKID_TWO   | main and skid registers both full, ready_o low
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned       DATA_W         = 32,
    parameter logic [DATA_W-1:0] RESET_VAL      = '0,
    parameter bit                SKID           = 1'b1,
    parameter bit                CLEAR_ON_FLUSH = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    pipe_skid_reg_if.slave  up_if,
    pipe_skid_reg_if.master dn_if,
    output logic [1:0]      count_o
);

    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_flush;

    generate
        if (CLEAR_ON_FLUSH) begin : g_flush_clr
            assign main_flush = RESET_VAL;
        end else begin : g_flush_hold
            assign main_flush = main_q;
        end
    endgenerate

    assign dn_if.data = main_q;

    generate
        if (SKID) begin : g_skid
            skid_state_e       state_q;
            skid_state_e       state_d;
            logic [DATA_W-1:0] skid_q;
            logic [DATA_W-1:0] skid_d;
            logic [DATA_W-1:0] skid_flush;
            logic              xfer_in;
            logic              xfer_out;

            // ready comes straight from the state flops; rst only masks it
            assign up_if.ready = !rst_i && (state_q != SKID_TWO);
            assign dn_if.valid = (state_q != SKID_EMPTY);
            assign count_o     = skid_count(state_q);
            assign xfer_in     = up_if.valid && up_if.ready;
            assign xfer_out    = dn_if.valid && dn_if.ready;
            assign skid_flush  = CLEAR_ON_FLUSH ? RESET_VAL : skid_q;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush_i) begin
                    state_d = SKID_EMPTY;
                    main_d  = main_flush;
                    skid_d  = skid_flush;
                end else begin
                    case (state_q)
                        SKID_EMPTY: begin
                            if (xfer_in) begin
                                state_d = SKID_ONE;
                                main_d  = up_if.data;
                            end
                        end
                        SKID_ONE: begin
                            if (xfer_in && xfer_out) begin
                                main_d = up_if.data;
                            end else if (xfer_in) begin
                                state_d = SKID_TWO;
                                skid_d  = up_if.data;
                            end else if (xfer_out) begin
                                state_d = SKID_EMPTY;
                            end
                        end
                        SKID_TWO: begin
                            if (xfer_out) begin
                                state_d = SKID_ONE;
                                main_d  = skid_q;
                            end
                        end
                        default: state_d = SKID_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state_q <= SKID_EMPTY;
                    main_q  <= RESET_VAL;
                    skid_q  <= RESET_VAL;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end
        end else begin : g_flat
            logic valid_q;
            logic valid_d;

            assign up_if.ready = !rst_i && (!valid_q || dn_if.ready);
            assign dn_if.valid = valid_q;
            assign count_o     = {1'b0, valid_q};

            always_comb begin
                valid_d = valid_q;
                main_d  = main_q;
                if (flush_i) begin
                    valid_d = 1'b0;
                    main_d  = main_flush;
                end else if (up_if.ready) begin
                    valid_d = up_if.valid;
                    if (up_if.valid) begin
                        main_d = up_if.data;
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    main_q  <= RESET_VAL;
                end else begin
                    valid_q <= valid_d;
                    main_q  <= main_d;
                end
            end
        end
    endgenerate

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register for the milano core, generalising the fixed-field stage register between decode and execute. It carries an opaque payload vector between any two pipeline stages with a valid/ready handshake, synchronous flush, and an optional two-entry skid buffer that registers the backward ready path. Instances sit at every IF/ID/EX/WB boundary; per-stage field packing is done by the instantiating stage.

## Interface
- DATA_W, 32: payload width in bits, 1..1024.
- RESET_VAL, '0: DATA_W-bit value loaded into payload registers at reset.
- SKID, 1: 0 = single register with combinational ready; 1 = two-entry skid buffer with registered ready.
- CLEAR_ON_FLUSH, 0: 1 = payload registers load RESET_VAL on flush; 0 = payload is held, only valid bits are cleared.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  synchronous kill of all held and incoming entries.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage accepts an entry this cycle.
- data_i  in  DATA_W  upstream payload.
- valid_o  out  1  downstream entry valid.
- ready_i  in  1  downstream accepts this cycle; low = stall.
- data_o  out  DATA_W  downstream payload, always taken from the main register.
- count_o  out  2  number of entries held: 0..1 for SKID=0, 0..2 for SKID=1.

## Operation
- Transfer in: valid_i & ready_o. Transfer out: valid_o & ready_i. valid_i must stay high, with data_i stable, until accepted; the same rule applies to valid_o/data_o.
- Reset (while rst_i high and after release): valid_o=0, count_o=0, data_o=RESET_VAL, skid register=RESET_VAL, state=SKID_EMPTY. ready_o=0 while rst_i is high.
- SKID=0: ready_o = !valid_q | ready_i (combinational). On a clock with ready_o high: valid_q<=valid_i; data_q<=data_i only when valid_i=1.
- SKID=1: ready_o = (state != SKID_TWO), driven from a register. States and transitions:
  - SKID_EMPTY: in -> SKID_ONE, main<=data_i.
  - SKID_ONE, in&out: stay; main<=data_i.
  - SKID_ONE, in only: -> SKID_TWO; skid<=data_i.
  - SKID_ONE, out only: -> SKID_EMPTY.
  - SKID_TWO, out: -> SKID_ONE; main<=skid. No input is possible in SKID_TWO.
- valid_o = (state != SKID_EMPTY). count_o: EMPTY=0, ONE=1, TWO=2.
- Flush has priority over every other event. On a clock with flush_i=1: all valid bits clear, state -> SKID_EMPTY, and any incoming entry is dropped even if ready_o=1. An output transfer in the same cycle still counts as delivered downstream. Payload registers follow CLEAR_ON_FLUSH.
- Payload is never interpreted; there are no arithmetic operations.

## Timing
- Latency: 1 cycle from input transfer to valid_o, in both modes.
- Throughput: 1 entry per cycle in both modes while ready_i=1.
- SKID=0: ready_o depends combinationally on ready_i. SKID=1: no combinational path from ready_i or valid_i to ready_o.
- After ready_i falls (SKID=1), at most one further entry is accepted; ready_o drops on the following cycle.
- Reset asserted mid-transfer: entries are discarded asynchronously, and outputs take their reset values within the same cycle.
- The flush takes effect at the clock edge where it is sampled. On the next cycle valid_o=0; ready_o=1 unless reset is asserted.

## Structure
- milano_pkg gains typedef enum logic [1:0] skid_state_e {SKID_EMPTY, SKID_ONE, SKID_TWO}.
- There is no sub-module. SKID and CLEAR_ON_FLUSH are selected with generate branches inside pipe_skid_reg.
- Stages pack their fields with packed structs in milano_pkg; DATA_W = $bits(struct).

## Test plan
- Reset: assert rst_i mid-stream with DATA_W=32, RESET_VAL=32'hDEAD_BEEF -> valid_o=0, count_o=0, data_o=32'hDEAD_BEEF immediately, and ready_o=0 until release.
- Streaming, SKID=1: push 0x1..0x8 on consecutive cycles with ready_i=1 -> data_o shows 0x1..0x8 on cycles 1..8, no bubbles, and count_o stays 1.
- Back-pressure, SKID=1: drop ready_i while 0x10 and 0x11 are in flight -> count_o=2, ready_o=0 next cycle. Raising ready_i then drains 0x10, then 0x11, in order with no loss.
- Combinational stall, SKID=0: valid_o=1 and ready_i=0 -> ready_o=0 in the same cycle, and data_o holds its value.
- Flush in SKID_TWO with valid_i=1, data_i=0x22 -> next cycle valid_o=0, count_o=0, and 0x22 is never output. With CLEAR_ON_FLUSH=1, data_o=RESET_VAL.
- Random valid_i/ready_i/flush_i over 10k cycles against a reference queue model -> identical output sequence, with count_o always ≤ 2.
